operand_dispatcher: RTL and testbench

- Upstream/downstream wrapper for the 16-bit two-operand compute core, which has A/B/start inputs and Y/done outputs.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches the core one pair at a time with a single-cycle start pulse, waits for done, and presents Y on a valid/ready result port.
- Carries a per-transaction latency count and a watchdog against a hung core.

---
 rtl/operand_dispatcher.sv | 114 +++++++++++
 tb/tb_operand_dispatcher.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_dispatcher.sv
// Buffers operand pairs in a small FIFO and runs a two-operand compute core one pair at a time.
// It captures each result with its latency and abandons a transaction if the core never signals done.
module operand_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      core_a,
  output logic [15:0]      core_b,
  output logic             core_start,
  input  logic [15:0]      core_y,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_y,
  output logic [CNT_W-1:0] out_cycles,
  output logic             timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t           state_reg;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_inc;
  logic [15:0]      core_a_reg, core_b_reg, out_y_reg;
  logic [CNT_W-1:0] out_cycles_reg;
  logic             core_start_reg, out_valid_reg, timeout_err_reg;
  logic             full, empty, push, pop, timeout_hit;

  assign full        = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign in_ready    = !full;
  assign push        = in_valid && !full;
  // A launch waits until the previous result has been consumed.
  assign pop         = (state_reg == IDLE) && !empty && !out_valid_reg;
  assign cnt_inc     = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
  assign timeout_hit = (int'(cnt_reg) == TIMEOUT - 1);

  assign core_a      = core_a_reg;
  assign core_b      = core_b_reg;
  assign core_start  = core_start_reg;
  assign out_valid   = out_valid_reg;
  assign out_y       = out_y_reg;
  assign out_cycles  = out_cycles_reg;
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      cnt_reg         <= '0;
      core_a_reg      <= '0;
      core_b_reg      <= '0;
      core_start_reg  <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_y_reg       <= '0;
      out_cycles_reg  <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      core_start_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;

      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (pop) begin
            {core_a_reg, core_b_reg} <= mem[rd_ptr_reg];
            cnt_reg        <= '0;
            core_start_reg <= 1'b1;
            state_reg      <= LAUNCH;
          end
        end
        LAUNCH: state_reg <= WAIT;
        WAIT: begin
          cnt_reg <= cnt_inc;
          // done takes priority over the watchdog on the same cycle
          if (core_done) begin
            out_y_reg      <= core_y;
            out_cycles_reg <= cnt_inc;
            out_valid_reg  <= 1'b1;
            state_reg      <= IDLE;
          end else if (timeout_hit) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_dispatcher.sv
// Directed bench for operand_dispatcher: a table of single transactions plus hand-written
// sequences for backpressure, watchdog, stray done and reset during a transaction.
module tb_operand_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic [15:0] core_a, core_b;
  logic        core_start;
  logic [15:0] core_y = '0;
  logic        core_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;
  logic [7:0]  out_cycles;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  operand_dispatcher #(.DEPTH(4), .TIMEOUT(200), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_start(core_start),
    .core_y(core_y), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_cycles(out_cycles), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Core model: Y = (A + B) ^ 0x313C, done raised during WAIT cycle number 'delay'.
  int          delay = 1;
  bit          hang = 1'b0;
  bit          force_done = 1'b0;
  bit          busy = 1'b0;
  int          k = 0;
  logic [15:0] ca = '0, cb = '0;

  function automatic logic [15:0] core_fn(input logic [15:0] a, input logic [15:0] b);
    return (a + b) ^ 16'h313C;
  endfunction

  always @(posedge clk) begin
    #1;
    core_done = force_done;
    if (force_done) core_y = 16'hBEEF;
    if (!rst) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        k = k + 1;
        if (!hang && k == delay) begin
          core_done = 1'b1;
          core_y    = core_fn(ca, cb);
          busy      = 1'b0;
        end
      end
      if (core_start) begin
        busy = 1'b1;
        k    = 0;
        ca   = core_a;
        cb   = core_b;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          dly;
    logic [15:0] y;
    logic [7:0]  cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic run_one(input vec_t v);
    int n, starts, tmo, held_bad;
    delay = v.dly;
    hang  = 1'b0;
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("no_early_start", core_start, 0);
    @(negedge clk);
    chk("start_pulse", core_start, 1);
    chk("core_a", core_a, v.a);
    chk("core_b", core_b, v.b);
    starts = 1; tmo = 0; held_bad = 0; n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
      if (core_start) starts++;
      if (timeout_err) tmo++;
      if (core_a !== v.a || core_b !== v.b) held_bad++;
    end
    chk("result_latency", n, v.dly + 1);
    chk("single_start", starts, 1);
    chk("no_timeout", tmo, 0);
    chk("operands_held", held_bad, 0);
    chk("out_y", out_y, v.y);
    chk("out_cycles", out_cycles, v.cyc);
    @(negedge clk);
    chk("hold_valid", out_valid, 1);
    chk("hold_y", out_y, v.y);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_cleared", out_valid, 0);
    $display("txn a=%h b=%h delay=%0d -> y=%h cycles=%0d", v.a, v.b, v.dly, v.y, v.cyc);
  endtask

  logic [15:0] bp_a[6], bp_b[6];
  int pushed, results, launches, last_cons, cnt_a, cnt_b, tmo_at, tmo_cnt, ov_cnt;

  initial begin
    vecs[0] = '{16'h1000, 16'h2E00, 5,   16'h0F3C, 8'd5};
    vecs[1] = '{16'h7FFF, 16'h0000, 3,   16'h4EC3, 8'd3};
    vecs[2] = '{16'hFFFF, 16'h0001, 1,   16'h313C, 8'd1};
    vecs[3] = '{16'h1234, 16'h4321, 7,   16'h6469, 8'd7};
    vecs[4] = '{16'h0000, 16'h0000, 2,   16'h313C, 8'd2};
    vecs[5] = '{16'h0ABC, 16'h0101, 200, 16'h3A81, 8'd200};  // done on the watchdog cycle

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_core_a", core_a, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_one(vecs[i]);

    // Backpressure: six back-to-back pairs, consumer stalled until cycle 15.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 16'h0011 + 16'(i * 16'h0100);
      bp_b[i] = 16'h2000 - 16'(i);
    end
    delay = 2; pushed = 0; results = 0; launches = 0; last_cons = -10;
    for (int c = 0; c < 400 && results < 6; c++) begin
      @(negedge clk);
      if (core_start) begin
        launches++;
        if (launches > 1) chk("bp_launch_gap", c - last_cons, 2);
      end
      if (c == 15) begin
        chk("bp_accepted_when_full", pushed, 5);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_first_result_held", out_valid, 1);
      end
      out_ready = (c >= 15);
      in_valid  = (pushed < 6);
      if (pushed < 6) begin
        in_a = bp_a[pushed];
        in_b = bp_b[pushed];
      end
      if (out_valid && out_ready) begin
        chk("bp_out_y", out_y, core_fn(bp_a[results], bp_b[results]));
        chk("bp_out_cycles", out_cycles, 2);
        $display("txn bp[%0d] y=%h cycles=%0d", results, out_y, out_cycles);
        results++;
        last_cons = c;
      end
      if (in_valid && in_ready) pushed++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_results", results, 6);
    chk("bp_launches", launches, 6);

    // Watchdog: first pair hangs, second one must run afterwards.
    hang = 1'b1; delay = 3;
    @(negedge clk);
    in_a = 16'hDEAD; in_b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    in_a = 16'h0ABC; in_b = 16'h0101;
    @(negedge clk);
    in_valid = 1'b0;
    for (int w = 0; w < 10 && !core_start; w++) @(negedge clk);
    chk("tmo_launch", core_start, 1);
    tmo_at = -1; tmo_cnt = 0; ov_cnt = 0;
    for (int j = 1; j <= 202; j++) begin
      @(negedge clk);
      if (timeout_err) begin
        tmo_cnt++;
        if (tmo_at < 0) tmo_at = j;
        hang = 1'b0;
      end
      if (out_valid) ov_cnt++;
      if (j == 202) begin
        chk("tmo_next_launch", core_start, 1);
        chk("tmo_next_a", core_a, 16'h0ABC);
      end
    end
    chk("tmo_position", tmo_at, 201);
    chk("tmo_single_pulse", tmo_cnt, 1);
    chk("tmo_no_result", ov_cnt, 0);
    for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
    chk("tmo_next_y", out_y, 16'h3A81);
    chk("tmo_next_cycles", out_cycles, 3);
    $display("txn timeout then a=0abc b=0101 -> y=%h", out_y);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Stray done while idle with nothing queued.
    @(negedge clk);
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    ov_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("stray_done_ignored", ov_cnt, 0);

    // Reset during LAUNCH drops core_start without waiting for an edge.
    hang = 1'b1;
    in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("launch_before_rst", core_start, 1);
    #2 rst = 1'b0;
    #1 chk("rst_async_start", core_start, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset during WAIT with two pairs queued.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h3000 + 16'(i); in_b = 16'h4000 + 16'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_core_a", core_a, 16'h3000);
    chk("pre_rst_full_queue", in_ready, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_core_a", core_a, 0);
    chk("rst_mid_core_b", core_b, 0);
    chk("rst_mid_start", core_start, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_tmo", timeout_err, 0);
    chk("rst_mid_out_y", out_y, 0);
    chk("rst_mid_out_cycles", out_cycles, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1; hang = 1'b0;
    cnt_a = 0; cnt_b = 0;
    repeat (30) begin
      @(negedge clk);
      if (core_start) cnt_a++;
      if (out_valid) cnt_b++;
    end
    chk("post_rst_no_launch", cnt_a, 0);
    chk("post_rst_no_result", cnt_b, 0);
    chk("post_rst_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
